// File: rtl/ghostbus_fanout.sv
// ghostbus_fanout: decodes one ghostbus host port into NCH address windows
// and returns read data through a tagged, fixed-latency readback pipe.
module ghostbus_fanout #(
    parameter int              AW         = 24,
    parameter int              DW         = 32,
    parameter int              NCH        = 4,
    parameter int              SUB_AW     = 8,
    parameter logic [AW-1:0]   BASE       = 24'h001000,
    parameter int              FWD_STAGES = 1,
    parameter int              RD_LAT     = 2,
    parameter int              RB_STAGES  = 1,
    parameter logic [DW-1:0]   MISS_VAL   = 32'hDEADBEEF
) (
    input  logic                gb_clk,
    input  logic                gb_rst,
    input  logic [AW-1:0]       gb_addr,
    input  logic [DW-1:0]       gb_wdata,
    input  logic                gb_wen,
    input  logic                gb_rstb,
    output logic [DW-1:0]       gb_rdata,
    output logic                gb_rvalid,
    output logic [SUB_AW-1:0]   ch_addr,
    output logic [DW-1:0]       ch_wdata,
    output logic [NCH-1:0]      ch_wen,
    output logic [NCH-1:0]      ch_rstb,
    input  logic [NCH*DW-1:0]   ch_rdata,
    output logic                miss,
    output logic [15:0]         miss_count
);
    localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
    localparam int FD = FWD_STAGES > 0 ? FWD_STAGES : 1;
    localparam int TD = RD_LAT > 0 ? RD_LAT : 1;
    localparam logic [AW:0] SPAN = (AW+1)'(NCH) << SUB_AW;

    typedef struct packed {
        logic              wen;
        logic              rstb;
        logic              rd;
        logic              hit;
        logic              miss;
        logic [CW-1:0]     chan;
        logic [SUB_AW-1:0] addr;
        logic [DW-1:0]     wdata;
    } fwd_t;

    typedef struct packed {
        logic          rd;
        logic          hit;
        logic [CW-1:0] chan;
    } tag_t;

    // One extra bit keeps addresses below BASE from wrapping into a window
    logic [AW:0] off;
    logic        hit;
    assign off = {1'b0, gb_addr} - {1'b0, BASE};
    assign hit = !off[AW] && off < SPAN;

    fwd_t s0, fin;
    fwd_t pipe [FD];
    always_comb begin
        s0.wen   = gb_wen & hit & ~gb_rst;
        s0.rstb  = gb_rstb & hit & ~gb_rst;
        s0.rd    = gb_rstb & ~gb_rst;
        s0.hit   = hit;
        s0.miss  = (gb_wen | gb_rstb) & ~hit & ~gb_rst;
        s0.chan  = off[SUB_AW +: CW];
        s0.addr  = off[SUB_AW-1:0];
        s0.wdata = gb_wdata;
    end

    always_ff @(posedge gb_clk) begin
        if (gb_rst) begin
            for (int i = 0; i < FD; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= s0;
            for (int i = 1; i < FD; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign fin = FWD_STAGES == 0 ? s0 : pipe[FD-1];

    logic              fin_stb;
    logic [SUB_AW-1:0] h_addr;
    logic [DW-1:0]     h_wdata;
    assign fin_stb  = fin.wen | fin.rstb;
    assign ch_addr  = fin_stb ? fin.addr : h_addr;
    assign ch_wdata = fin_stb ? fin.wdata : h_wdata;
    assign ch_wen   = NCH'(fin.wen) << fin.chan;
    assign ch_rstb  = NCH'(fin.rstb) << fin.chan;
    assign miss     = fin.miss;

    always_ff @(posedge gb_clk) begin
        if (gb_rst) begin
            h_addr     <= '0;
            h_wdata    <= '0;
            miss_count <= '0;
        end else begin
            if (fin_stb) begin
                h_addr  <= fin.addr;
                h_wdata <= fin.wdata;
            end
            if (fin.miss && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
        end
    end

    tag_t t0, emerge;
    tag_t tags [TD];
    assign t0 = '{rd: fin.rd, hit: fin.hit, chan: fin.chan};

    always_ff @(posedge gb_clk) begin
        if (gb_rst) begin
            for (int i = 0; i < TD; i++) tags[i] <= '0;
        end else begin
            tags[0] <= t0;
            for (int i = 1; i < TD; i++) tags[i] <= tags[i-1];
        end
    end
    assign emerge = RD_LAT == 0 ? t0 : tags[TD-1];

    logic [DW-1:0] sel;
    assign sel = emerge.hit ? ch_rdata[DW*int'(emerge.chan) +: DW] : MISS_VAL;

    // Only the output stage holds its word between reads
    logic [DW-1:0]        rb_d [RB_STAGES];
    logic [RB_STAGES-1:0] rb_v;
    always_ff @(posedge gb_clk) begin
        if (gb_rst) begin
            rb_v <= '0;
            for (int i = 0; i < RB_STAGES; i++) rb_d[i] <= '0;
        end else begin
            rb_v[0] <= emerge.rd;
            if (RB_STAGES > 1 || emerge.rd) rb_d[0] <= sel;
            for (int i = 1; i < RB_STAGES; i++) begin
                rb_v[i] <= rb_v[i-1];
                if (i < RB_STAGES-1 || rb_v[i-1]) rb_d[i] <= rb_d[i-1];
            end
        end
    end
    assign gb_rdata  = rb_d[RB_STAGES-1];
    assign gb_rvalid = rb_v[RB_STAGES-1];
endmodule
